note_voice_scheduler: RTL and testbench

//  Sits between PS2_Controller and the 7 square-wave voice generators. Parses the raw
//  PS/2 byte stream (make, F0 break, E0 extended), keeps note gates, octave and accidental

---
 rtl/note_voice_scheduler_if.sv | 27 ++
 rtl/note_voice_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_note_voice_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/note_voice_scheduler_if.sv
// Keyboard-to-voice-bank bundle: PS/2 byte input, panel state outputs and the
// valid/ready period write port into the seven square-wave voice generators.
interface note_voice_scheduler_if #(
    parameter int PW = 24
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [6:0]        note_on;
    logic signed [3:0] octave;
    logic              sharp;
    logic              flat;
    logic              period_vld;
    logic              period_rdy;
    logic [2:0]        period_idx;
    logic [PW-1:0]     period_val;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, period_rdy,
        output note_on, octave, sharp, flat, period_vld, period_idx, period_val, busy
    );

    modport slave (
        output rx_data, rx_valid, period_rdy,
        input  note_on, octave, sharp, flat, period_vld, period_idx, period_val, busy
    );
endinterface

// File: rtl/note_voice_scheduler.sv
// PS/2 note parser plus a shared iterative divider that computes voice half-periods.
// Optional simultaneous-note cap is enabled with `define NOTE_SCHED_VOICE_LIMIT_EN.
module note_voice_scheduler #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PW         = 24,
    parameter int OCT_MAX    = 4,
    parameter int MAX_VOICES = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    note_voice_scheduler_if.master bus
);
    localparam logic [31:0]        HALF_CLK = 32'(CLK_HZ / 2);
    localparam logic signed [3:0]  OCT_HI   = 4'(OCT_MAX);
    localparam logic signed [3:0]  OCT_LO   = -OCT_HI;

    typedef enum logic [1:0] {P_IDLE = 2'd0, P_BRK = 2'd1, P_EXT = 2'd2, P_EBRK = 2'd3} pstate_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_SHIFT = 2'd2, S_OUT = 2'd3} sstate_t;

    pstate_t           pstate_r, pstate_next;
    sstate_t           sstate_r, sstate_next;
    logic [6:0]        note_on_r, note_on_next;
    logic signed [3:0] octave_r, octave_next, oct_snap_r;
    logic              sharp_r, sharp_next, flat_r, flat_next;
    logic [6:0]        dirty_r, dirty_set_s, dirty_clr_s, dirty_next_s;
    logic [3:0]        lookup_s;
    logic              note_hit_s, make_ok_s;
    logic [6:0]        note_mask_s;
    logic [2:0]        pick_s, idx_r;
    logic [15:0]       divisor_r;
    logic [31:0]       rem_r, quo_r, trial_s, rem_step_s, quo_step_s;
    logic [4:0]        cnt_r;
    logic [PW-1:0]     val_r;
    logic              vld_r, busy_r;

    // Returns {hit, voice index}; voice index follows the note_on bit order.
    function automatic logic [3:0] note_lookup(input logic [7:0] code);
        case (code)
            8'h16:   note_lookup = {1'b1, 3'd6};
            8'h1E:   note_lookup = {1'b1, 3'd5};
            8'h26:   note_lookup = {1'b1, 3'd4};
            8'h25:   note_lookup = {1'b1, 3'd3};
            8'h2E:   note_lookup = {1'b1, 3'd2};
            8'h36:   note_lookup = {1'b1, 3'd1};
            8'h3D:   note_lookup = {1'b1, 3'd0};
            default: note_lookup = 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] freq_of(input logic [2:0] idx, input logic sh, input logic fl);
        if (sh) begin
            case (idx)
                3'd6: freq_of = 16'd466;  3'd5: freq_of = 16'd523;  3'd4: freq_of = 16'd554;
                3'd3: freq_of = 16'd622;  3'd2: freq_of = 16'd698;  3'd1: freq_of = 16'd740;
                default: freq_of = 16'd831;
            endcase
        end else if (fl) begin
            case (idx)
                3'd6: freq_of = 16'd415;  3'd5: freq_of = 16'd466;  3'd4: freq_of = 16'd494;
                3'd3: freq_of = 16'd554;  3'd2: freq_of = 16'd622;  3'd1: freq_of = 16'd659;
                default: freq_of = 16'd740;
            endcase
        end else begin
            case (idx)
                3'd6: freq_of = 16'd440;  3'd5: freq_of = 16'd494;  3'd4: freq_of = 16'd523;
                3'd3: freq_of = 16'd587;  3'd2: freq_of = 16'd659;  3'd1: freq_of = 16'd698;
                default: freq_of = 16'd784;
            endcase
        end
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [6:0] d);
        casez (d)
            7'b??????1: lowest_idx = 3'd0;
            7'b?????10: lowest_idx = 3'd1;
            7'b????100: lowest_idx = 3'd2;
            7'b???1000: lowest_idx = 3'd3;
            7'b??10000: lowest_idx = 3'd4;
            7'b?100000: lowest_idx = 3'd5;
            7'b1000000: lowest_idx = 3'd6;
            default:    lowest_idx = 3'd0;
        endcase
    endfunction

    // Positive octaves halve the period, negative ones double it up to full scale.
    function automatic logic [PW-1:0] shift_sat(input logic [31:0] q, input logic signed [3:0] oct);
        logic [47:0] wide;
        logic [3:0]  amt;
        amt = oct[3] ? 4'(-oct) : 4'(oct);
        if (oct[3]) begin
            wide = {16'd0, q} << amt;
        end else begin
            wide = {16'd0, q} >> amt;
        end
        if (|wide[47:PW]) begin
            shift_sat = {PW{1'b1}};
        end else begin
            shift_sat = wide[PW-1:0];
        end
    endfunction

`ifdef NOTE_SCHED_VOICE_LIMIT_EN
    function automatic logic [2:0] popcount7(input logic [6:0] v);
        popcount7 = 3'd0;
        for (int i = 0; i < 7; i++) begin
            popcount7 = popcount7 + {2'd0, v[i]};
        end
    endfunction

    assign make_ok_s = (popcount7(note_on_r) != 3'(MAX_VOICES));
`else
    // Without the cap any non-negative MAX_VOICES admits every make.
    assign make_ok_s = (MAX_VOICES >= 0);
`endif

    assign lookup_s    = note_lookup(bus.rx_data);
    assign note_hit_s  = lookup_s[3];
    assign note_mask_s = 7'd1 << lookup_s[2:0];
    assign pick_s      = lowest_idx(dirty_r);

    // Parser next-state: byte stream decode into gates, octave and accidentals.
    always_comb begin
        pstate_next  = pstate_r;
        note_on_next = note_on_r;
        octave_next  = octave_r;
        sharp_next   = sharp_r;
        flat_next    = flat_r;
        dirty_set_s  = 7'd0;
        if (bus.rx_valid) begin
            case (pstate_r)
                P_IDLE: begin
                    if (bus.rx_data == 8'hF0) begin
                        pstate_next = P_BRK;
                    end else if (bus.rx_data == 8'hE0) begin
                        pstate_next = P_EXT;
                    end else if (note_hit_s && ((note_on_r & note_mask_s) == 7'd0) && make_ok_s) begin
                        note_on_next = note_on_r | note_mask_s;
                        dirty_set_s  = note_mask_s;
                    end else begin
                        note_on_next = note_on_r;
                    end
                end
                P_BRK: begin
                    pstate_next = P_IDLE;
                    if (note_hit_s) begin
                        note_on_next = note_on_r & ~note_mask_s;
                    end else begin
                        note_on_next = note_on_r;
                    end
                end
                P_EXT: begin
                    pstate_next = P_IDLE;
                    case (bus.rx_data)
                        8'h75: begin
                            if (octave_r < OCT_HI) begin
                                octave_next = octave_r + 4'sd1;
                                dirty_set_s = 7'h7F;
                            end else begin
                                octave_next = octave_r;
                            end
                        end
                        8'h72: begin
                            if (octave_r > OCT_LO) begin
                                octave_next = octave_r - 4'sd1;
                                dirty_set_s = 7'h7F;
                            end else begin
                                octave_next = octave_r;
                            end
                        end
                        8'h6B: begin
                            flat_next   = ~flat_r;
                            dirty_set_s = 7'h7F;
                        end
                        8'h74: begin
                            sharp_next  = ~sharp_r;
                            dirty_set_s = 7'h7F;
                        end
                        8'hF0:   pstate_next = P_EBRK;
                        default: pstate_next = P_IDLE;
                    endcase
                end
                P_EBRK:  pstate_next = P_IDLE;
                default: pstate_next = P_IDLE;
            endcase
        end else begin
            pstate_next = pstate_r;
        end
    end

    // Parser state and panel registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pstate_r  <= P_IDLE;
            note_on_r <= 7'd0;
            octave_r  <= 4'sd0;
            sharp_r   <= 1'b0;
            flat_r    <= 1'b0;
        end else begin
            pstate_r  <= pstate_next;
            note_on_r <= note_on_next;
            octave_r  <= octave_next;
            sharp_r   <= sharp_next;
            flat_r    <= flat_next;
        end
    end

    // Scheduler next-state; a same-cycle set beats the clear via dirty_next_s.
    always_comb begin
        sstate_next = sstate_r;
        dirty_clr_s = 7'd0;
        case (sstate_r)
            S_IDLE: begin
                if (dirty_r != 7'd0) begin
                    sstate_next = S_DIV;
                    dirty_clr_s = 7'd1 << pick_s;
                end else begin
                    sstate_next = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt_r == 5'd31) begin
                    sstate_next = S_SHIFT;
                end else begin
                    sstate_next = S_DIV;
                end
            end
            S_SHIFT: sstate_next = S_OUT;
            S_OUT: begin
                if (bus.period_rdy) begin
                    sstate_next = S_IDLE;
                end else begin
                    sstate_next = S_OUT;
                end
            end
            default: sstate_next = S_IDLE;
        endcase
    end

    assign dirty_next_s = (dirty_r & ~dirty_clr_s) | dirty_set_s;

    // One restoring-division step: quo_r shifts the dividend out and quotient bits in.
    always_comb begin
        trial_s = {rem_r[30:0], quo_r[31]};
        if (trial_s >= {16'd0, divisor_r}) begin
            rem_step_s = trial_s - {16'd0, divisor_r};
            quo_step_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_step_s = trial_s;
            quo_step_s = {quo_r[30:0], 1'b0};
        end
    end

    // Scheduler state, divider datapath and registered write port.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sstate_r   <= S_IDLE;
            dirty_r    <= 7'h7F;
            idx_r      <= 3'd0;
            divisor_r  <= 16'd0;
            oct_snap_r <= 4'sd0;
            rem_r      <= 32'd0;
            quo_r      <= 32'd0;
            cnt_r      <= 5'd0;
            val_r      <= {PW{1'b0}};
            vld_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            sstate_r <= sstate_next;
            dirty_r  <= dirty_next_s;
            vld_r    <= (sstate_next == S_OUT);
            busy_r   <= (sstate_next != S_IDLE) || (dirty_next_s != 7'd0);
            case (sstate_r)
                S_IDLE: begin
                    if (dirty_r != 7'd0) begin
                        idx_r      <= pick_s;
                        divisor_r  <= freq_of(pick_s, sharp_r, flat_r);
                        oct_snap_r <= octave_r;
                        rem_r      <= 32'd0;
                        quo_r      <= HALF_CLK;
                        cnt_r      <= 5'd0;
                    end
                end
                S_DIV: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                S_SHIFT: val_r <= shift_sat(quo_r, oct_snap_r);
                default: ;
            endcase
        end
    end

    assign bus.note_on    = note_on_r;
    assign bus.octave     = octave_r;
    assign bus.sharp      = sharp_r;
    assign bus.flat       = flat_r;
    assign bus.period_vld = vld_r;
    assign bus.period_idx = idx_r;
    assign bus.period_val = val_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_note_voice_scheduler.sv
// Directed bench for note_voice_scheduler: expected periods are (25e6/freq) shifted by octave.
module tb_note_voice_scheduler;
    localparam int PW = 24;

    logic CLOCK_50 = 1'b0;
    logic reset;
    always #10 CLOCK_50 = ~CLOCK_50;

    note_voice_scheduler_if #(.PW(PW)) bus ();

    note_voice_scheduler #(
        .CLK_HZ(50_000_000), .PW(PW), .OCT_MAX(4), .MAX_VOICES(3)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus)
    );

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [2:0]  wr_idx[$];
    logic [31:0] wr_val[$];
    int base;

    // Record every completed period write.
    always @(posedge CLOCK_50) begin
        if (!reset && bus.period_vld && bus.period_rdy) begin
            wr_idx.push_back(bus.period_idx);
            wr_val.push_back(32'(bus.period_val));
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge CLOCK_50);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge CLOCK_50);
        while (bus.busy && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_val(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [31:0] last_val(input logic [2:0] i);
        for (int k = wr_idx.size() - 1; k >= 0; k--) begin
            if (wr_idx[k] == i) return wr_val[k];
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_full_sweep(input string tag, input int b);
        check_val({tag, "_count"}, 32'(wr_idx.size() - b), 32'd7);
        if (wr_idx.size() >= b + 7) begin
            for (int i = 0; i < 7; i++) begin
                check_val({tag, "_order"}, {29'd0, wr_idx[b + i]}, 32'(i));
            end
            check_val({tag, "_G"}, wr_val[b], 32'd31887);
            check_val({tag, "_A"}, wr_val[b + 6], 32'd56818);
        end
    endtask

    initial begin
        logic [2:0]  hold_idx;
        logic [31:0] hold_val;
        logic        stable;
        int          n;

        reset = 1'b1;
        bus.rx_data = 8'd0;
        bus.rx_valid = 1'b0;
        bus.period_rdy = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check_val("rst_note_on", {25'd0, bus.note_on}, 32'd0);
        check_val("rst_octave", {28'd0, bus.octave}, 32'd0);
        check_val("rst_flags", {28'd0, bus.sharp, bus.flat, bus.period_vld, bus.busy}, 32'd0);

        // Reset release: full sweep in index order
        base = wr_idx.size();
        reset = 1'b0;
        wait_idle("sweep_idle", 400);
        check_full_sweep("sweep", base);

        // Make / break of A; unknown code ignored
        base = wr_idx.size();
        send_byte(8'h16);
        check_val("make_A", {25'd0, bus.note_on}, 32'h40);
        wait_idle("make_idle", 100);
        check_val("make_writes", 32'(wr_idx.size() - base), 32'd1);
        check_val("make_A_val", last_val(3'd6), 32'd56818);
        base = wr_idx.size();
        send_byte(8'hF0);
        send_byte(8'h16);
        send_byte(8'h1C);
        check_val("break_A", {25'd0, bus.note_on}, 32'd0);
        wait_idle("break_idle", 100);
        check_val("break_writes", 32'(wr_idx.size() - base), 32'd0);

        // Octave up in single steps; the saturated step must write nothing
        for (int s = 1; s <= 5; s++) begin
            base = wr_idx.size();
            send_byte(8'hE0);
            send_byte(8'h75);
            wait_idle("oct_up_idle", 400);
            check_val("oct_up_writes", 32'(wr_idx.size() - base), (s <= 4) ? 32'd7 : 32'd0);
        end
        check_val("oct_hi", {28'd0, bus.octave}, 32'd4);
        check_val("oct_hi_A", last_val(3'd6), 32'd3551);
        check_val("oct_hi_G", last_val(3'd0), 32'd1992);

        // Octave down back-to-back while the divider is busy
        for (int s = 0; s < 9; s++) begin
            send_byte(8'hE0);
            send_byte(8'h72);
        end
        wait_idle("oct_dn_idle", 3000);
        check_val("oct_lo", {28'd0, bus.octave}, 32'hC);
        check_val("oct_lo_A", last_val(3'd6), 32'd909088);
        check_val("oct_lo_G", last_val(3'd0), 32'd510192);

        // Extended break swallows one byte; the next byte parses normally
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_val("ebrk_octave", {28'd0, bus.octave}, 32'hC);
        send_byte(8'h16);
        check_val("ebrk_then_make", {25'd0, bus.note_on}, 32'h40);
        send_byte(8'hF0);
        send_byte(8'h16);
        wait_idle("ebrk_idle", 400);

        // Accidentals: sharp wins over flat, then flat alone
        for (int s = 0; s < 4; s++) begin
            send_byte(8'hE0);
            send_byte(8'h75);
        end
        send_byte(8'hE0);
        send_byte(8'h74);
        send_byte(8'hE0);
        send_byte(8'h6B);
        wait_idle("acc_idle", 3000);
        check_val("acc_flags", {30'd0, bus.sharp, bus.flat}, 32'd3);
        check_val("sharp_A", last_val(3'd6), 32'd53648);
        check_val("sharp_G", last_val(3'd0), 32'd30084);
        send_byte(8'hE0);
        send_byte(8'h74);
        wait_idle("flat_idle", 400);
        check_val("flat_A", last_val(3'd6), 32'd60240);

        // Back-pressure: write held stable while period_rdy is low
        bus.period_rdy = 1'b0;
        base = wr_idx.size();
        send_byte(8'h1E);
        n = 0;
        while (!bus.period_vld && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_val("hold_vld", {31'd0, bus.period_vld}, 32'd1);
        hold_idx = bus.period_idx;
        hold_val = 32'(bus.period_val);
        stable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLOCK_50);
            if (!bus.period_vld || bus.period_idx != hold_idx || 32'(bus.period_val) != hold_val)
                stable = 1'b0;
        end
        check_val("hold_stable", {31'd0, stable}, 32'd1);
        check_val("hold_idx", {29'd0, hold_idx}, 32'd5);
        check_val("hold_val", hold_val, 32'd53648);
        check_val("hold_no_write", 32'(wr_idx.size() - base), 32'd0);
        bus.period_rdy = 1'b1;
        wait_idle("hold_idle", 100);
        check_val("hold_release", 32'(wr_idx.size() - base), 32'd1);

        // Reset in the middle of a division aborts and restarts the sweep
        send_byte(8'hE0);
        send_byte(8'h74);
        repeat (10) @(negedge CLOCK_50);
        check_val("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_vld", {31'd0, bus.period_vld}, 32'd0);
        check_val("mid_rst_state", {23'd0, bus.note_on, bus.sharp, bus.flat}, 32'd0);
        repeat (2) @(negedge CLOCK_50);
        base = wr_idx.size();
        reset = 1'b0;
        @(negedge CLOCK_50);
        check_val("post_rst_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle("rerun_idle", 400);
        check_full_sweep("rerun", base);

`ifdef NOTE_SCHED_VOICE_LIMIT_EN
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        check_val("cap_full", {25'd0, bus.note_on}, 32'h70);
        send_byte(8'hF0);
        send_byte(8'h16);
        send_byte(8'h25);
        check_val("cap_reuse", {25'd0, bus.note_on}, 32'h38);
        wait_idle("cap_idle", 400);
`else
        base = wr_idx.size();
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        send_byte(8'h2E);
        send_byte(8'h36);
        send_byte(8'h3D);
        send_byte(8'h16);
        check_val("all_voices", {25'd0, bus.note_on}, 32'h7F);
        wait_idle("all_idle", 600);
        check_val("all_writes", 32'(wr_idx.size() - base), 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
